// File: rtl/i2c_xfer_seq.sv
// -----------------------------------------------------------------------------
// i2c_xfer_seq
//
// Register-style transaction sequencer in front of the I2C byte controller.
// One request (device, register address, 1..4 data bytes, read or write) is
// expanded into the byte-command stream:
//   write: START+WRITE {dev,0}, WRITE reg[MSB..LSB], WRITE data[0..len], STOP
//   read : START+WRITE {dev,0}, WRITE reg[MSB..LSB], START+WRITE {dev,1},
//          READ x (len+1) (last one NACKed), STOP
// and a single response (read data + status) is returned.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   req_*                    request channel (valid/ready handshake)
//   rsp_*                    response channel, held until rsp_ready_i
//                            rsp_err_o: 00 ok, 01 NACK, 10 arb lost, 11 timeout
//   byte_start/stop/read/write_o, byte_ack_o, byte_din_o
//                            command port to the byte controller (levels,
//                            held until byte_done_i)
//   byte_done_i, byte_ack_i, byte_dout_i, byte_al_i
//                            completion/status from the byte controller
// -----------------------------------------------------------------------------
module i2c_xfer_seq #(
    parameter int REG_ADDR_BYTES = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,

    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_rw_i,
    input  logic [6:0]                  req_dev_i,
    input  logic [8*REG_ADDR_BYTES-1:0] req_reg_i,
    input  logic [1:0]                  req_len_i,
    input  logic [31:0]                 req_wdata_i,

    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [31:0]                 rsp_rdata_o,
    output logic [1:0]                  rsp_err_o,

    output logic                        byte_start_o,
    output logic                        byte_stop_o,
    output logic                        byte_read_o,
    output logic                        byte_write_o,
    output logic                        byte_ack_o,
    output logic [7:0]                  byte_din_o,
    input  logic                        byte_done_i,
    input  logic                        byte_ack_i,
    input  logic [7:0]                  byte_dout_i,
    input  logic                        byte_al_i
);

    localparam int             RW       = 8 * REG_ADDR_BYTES;
    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]     REG_LAST = 2'(REG_ADDR_BYTES - 1);

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_NACK = 2'b01;
    localparam logic [1:0] ERR_AL   = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        DEV_W,
        REG,
        WDATA,
        RESTART,
        RDATA,
        STOP,
        RSP
    } state_t;

    state_t          state;

    // Latched request
    logic            rw_q;
    logic [6:0]      dev_q;
    logic [RW-1:0]   reg_q;
    logic [1:0]      len_q;
    logic [31:0]     wdata_q;

    // Byte index within the current phase (register bytes or data bytes)
    logic [1:0]      idx;
    logic [TW-1:0]   tmo_cnt;

    // A command is outstanding whenever one of the command levels is high;
    // start always travels with write, so it needs no separate term.
    logic            cmd_busy;
    assign cmd_busy = byte_read_o | byte_write_o | byte_stop_o;

    logic            data_last;
    logic            reg_last;
    assign data_last = (idx == len_q);
    assign reg_last  = (idx == REG_LAST);

    // Register address bytes go out MSB first.
    logic [15:0]     reg_ext;
    logic [7:0]      reg_byte;
    assign reg_ext  = 16'(reg_q);
    assign reg_byte = (REG_ADDR_BYTES == 2 && idx == 2'd0) ? reg_ext[15:8] : reg_ext[7:0];

    // Command that the current state issues next (registered on issue).
    logic            nxt_start, nxt_stop, nxt_read, nxt_write, nxt_ack;
    logic [7:0]      nxt_din;

    always_comb begin
        nxt_start = 1'b0;
        nxt_stop  = 1'b0;
        nxt_read  = 1'b0;
        nxt_write = 1'b0;
        nxt_ack   = 1'b0;
        nxt_din   = 8'h00;
        case (state)
            DEV_W: begin
                nxt_start = 1'b1;
                nxt_write = 1'b1;
                nxt_din   = {dev_q, 1'b0};
            end
            REG: begin
                nxt_write = 1'b1;
                nxt_din   = reg_byte;
            end
            WDATA: begin
                nxt_write = 1'b1;
                nxt_din   = wdata_q[{idx, 3'b000} +: 8];
            end
            RESTART: begin
                nxt_start = 1'b1;
                nxt_write = 1'b1;
                nxt_din   = {dev_q, 1'b1};
            end
            RDATA: begin
                nxt_read  = 1'b1;
                // NACK the final byte so the slave releases SDA before STOP
                nxt_ack   = data_last;
            end
            STOP: begin
                nxt_stop  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            rw_q         <= 1'b0;
            dev_q        <= '0;
            reg_q        <= '0;
            len_q        <= '0;
            wdata_q      <= '0;
            idx          <= '0;
            tmo_cnt      <= '0;
            req_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_rdata_o  <= '0;
            rsp_err_o    <= ERR_OK;
            {byte_start_o, byte_stop_o, byte_read_o, byte_write_o,
             byte_ack_o, byte_din_o} <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        rw_q        <= req_rw_i;
                        dev_q       <= req_dev_i;
                        reg_q       <= req_reg_i;
                        len_q       <= req_len_i;
                        wdata_q     <= req_wdata_i;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= ERR_OK;
                        idx         <= '0;
                        req_ready_o <= 1'b0;
                        state       <= DEV_W;
                    end
                end

                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end

                // All command states share the issue / wait / complete cycle.
                default: begin
                    if (byte_al_i) begin
                        // Bus is no longer ours: no STOP, report immediately.
                        if (rsp_err_o == ERR_OK) rsp_err_o <= ERR_AL;
                        {byte_start_o, byte_stop_o, byte_read_o, byte_write_o,
                         byte_ack_o, byte_din_o} <= '0;
                        rsp_valid_o <= 1'b1;
                        state       <= RSP;
                    end else if (!cmd_busy) begin
                        {byte_start_o, byte_stop_o, byte_read_o, byte_write_o,
                         byte_ack_o, byte_din_o} <=
                            {nxt_start, nxt_stop, nxt_read, nxt_write, nxt_ack, nxt_din};
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Timeout outranks a completion arriving in the same cycle.
                        if (rsp_err_o == ERR_OK) rsp_err_o <= ERR_TMO;
                        {byte_start_o, byte_stop_o, byte_read_o, byte_write_o,
                         byte_ack_o, byte_din_o} <= '0;
                        rsp_valid_o <= 1'b1;
                        state       <= RSP;
                    end else if (byte_done_i) begin
                        {byte_start_o, byte_stop_o, byte_read_o, byte_write_o,
                         byte_ack_o, byte_din_o} <= '0;
                        case (state)
                            DEV_W: begin
                                if (byte_ack_i) begin
                                    if (rsp_err_o == ERR_OK) rsp_err_o <= ERR_NACK;
                                    state <= STOP;
                                end else begin
                                    idx   <= '0;
                                    state <= REG;
                                end
                            end
                            REG: begin
                                if (byte_ack_i) begin
                                    if (rsp_err_o == ERR_OK) rsp_err_o <= ERR_NACK;
                                    state <= STOP;
                                end else if (reg_last) begin
                                    idx   <= '0;
                                    state <= rw_q ? RESTART : WDATA;
                                end else begin
                                    idx   <= idx + 2'd1;
                                end
                            end
                            WDATA: begin
                                if (byte_ack_i) begin
                                    if (rsp_err_o == ERR_OK) rsp_err_o <= ERR_NACK;
                                    state <= STOP;
                                end else if (data_last) begin
                                    state <= STOP;
                                end else begin
                                    idx   <= idx + 2'd1;
                                end
                            end
                            RESTART: begin
                                if (byte_ack_i) begin
                                    if (rsp_err_o == ERR_OK) rsp_err_o <= ERR_NACK;
                                    state <= STOP;
                                end else begin
                                    idx   <= '0;
                                    state <= RDATA;
                                end
                            end
                            RDATA: begin
                                rsp_rdata_o[{idx, 3'b000} +: 8] <= byte_dout_i;
                                if (data_last) state <= STOP;
                                else           idx   <= idx + 2'd1;
                            end
                            STOP: begin
                                rsp_valid_o <= 1'b1;
                                state       <= RSP;
                            end
                            default: state <= IDLE;
                        endcase
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
module tb_i2c_xfer_seq;

    localparam int TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_rw_i = 1'b0;
    logic [6:0]  req_dev_i = '0;
    logic [7:0]  req_reg_i = '0;
    logic [1:0]  req_len_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_err_o;
    logic        byte_start_o, byte_stop_o, byte_read_o, byte_write_o, byte_ack_o;
    logic [7:0]  byte_din_o;
    logic        byte_done_i = 1'b0;
    logic        byte_ack_i = 1'b0;
    logic [7:0]  byte_dout_i = '0;
    logic        byte_al_i = 1'b0;

    i2c_xfer_seq #(.REG_ADDR_BYTES(1), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rw_i(req_rw_i),
        .req_dev_i(req_dev_i), .req_reg_i(req_reg_i), .req_len_i(req_len_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o),
        .byte_start_o(byte_start_o), .byte_stop_o(byte_stop_o), .byte_read_o(byte_read_o),
        .byte_write_o(byte_write_o), .byte_ack_o(byte_ack_o), .byte_din_o(byte_din_o),
        .byte_done_i(byte_done_i), .byte_ack_i(byte_ack_i), .byte_dout_i(byte_dout_i),
        .byte_al_i(byte_al_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations from the last transaction. Each command is encoded as 12 bits
    // {start,stop,read,write, payload}; payload = din for writes, {7'b0,ack} for
    // reads, 0 for stop.
    logic [119:0] obs_seq;
    int           obs_n;
    logic [31:0]  obs_rdata;
    logic [1:0]   obs_err;
    int           obs_viol;
    int           obs_hi_last;
    int           obs_lat;
    int           obs_gap;
    bit           obs_to;

    // Model expectations
    logic [119:0] exp_seq;
    int           exp_n;
    logic [31:0]  exp_rdata;
    logic [1:0]   exp_err;

    function automatic logic [48:0] outs_now();
        return {req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, byte_start_o,
                byte_stop_o, byte_read_o, byte_write_o, byte_ack_o, byte_din_o};
    endfunction

    // Reference: ideal command list of the transaction, then walk it applying
    // the injected faults (k = index of the command in issue order).
    function automatic void model(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                                  input logic [1:0] len, input logic [31:0] wd,
                                  input logic [31:0] rd, input int nack_k, input int al_k,
                                  input int stall_k);
        logic [11:0] ideal[$];
        int ri;
        ideal.push_back({4'b1001, dev, 1'b0});
        ideal.push_back({4'b0001, rg});
        if (!rw) begin
            for (int i = 0; i <= int'(len); i++) ideal.push_back({4'b0001, wd[8*i +: 8]});
        end else begin
            ideal.push_back({4'b1001, dev, 1'b1});
            for (int i = 0; i <= int'(len); i++) ideal.push_back({4'b0010, 7'b0, i == int'(len)});
        end
        ideal.push_back({4'b0100, 8'h00});
        exp_seq = '0; exp_n = 0; exp_rdata = '0; exp_err = 2'b00; ri = 0;
        for (int k = 0; k < ideal.size(); k++) begin
            exp_seq[12*k +: 12] = ideal[k];
            exp_n = k + 1;
            if (k == al_k)    begin exp_err = 2'b10; return; end
            if (k == stall_k) begin exp_err = 2'b11; return; end
            if (ideal[k][8] && k == nack_k) begin
                exp_err = 2'b01;
                exp_seq[12*(k+1) +: 12] = {4'b0100, 8'h00};
                exp_n = k + 2;
                return;
            end
            if (ideal[k][9]) begin
                exp_rdata[8*ri +: 8] = rd[8*ri +: 8];
                ri++;
            end
        end
    endfunction

    // Drives one request, plays the byte controller, collects observations.
    task automatic run_txn(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [1:0] len, input logic [31:0] wd, input logic [31:0] rd,
                           input int nack_k, input int al_k, input int stall_k,
                           input int abort_k, input int hold);
        bit in_cmd, active, got_rsp;
        int k, rn, hi, wait_n, drop_cyc, w;
        logic [12:0] cur;
        obs_seq = '0; obs_n = 0; obs_viol = 0; obs_hi_last = 0; obs_lat = -1;
        obs_gap = -1; obs_to = 0; obs_rdata = '0; obs_err = '0;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_rw_i = rw; req_dev_i = dev; req_reg_i = rg;
        req_len_i = len; req_wdata_i = wd;
        w = 0;
        while (req_ready_o !== 1'b1 && w < 20) begin @(negedge clk_i); w++; end
        if (req_ready_o !== 1'b1) begin req_valid_i = 1'b0; obs_to = 1; return; end
        @(negedge clk_i);
        req_valid_i = 1'b0;
        if (req_ready_o !== 1'b0) obs_viol++;
        in_cmd = 0; k = 0; rn = 0; hi = 0; wait_n = 0; drop_cyc = -100; got_rsp = 0; cur = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk_i);
            byte_done_i = 1'b0; byte_al_i = 1'b0; byte_ack_i = 1'b0;
            active = byte_read_o | byte_write_o | byte_stop_o;
            if (req_ready_o !== 1'b0) obs_viol++;
            if (!active && in_cmd) begin in_cmd = 0; k++; drop_cyc = cyc; end
            if (rsp_valid_o === 1'b1) begin obs_gap = cyc - drop_cyc; got_rsp = 1; break; end
            if (active && !in_cmd) begin
                in_cmd = 1; hi = 0; wait_n = $urandom_range(0, 3);
                if (obs_lat < 0) obs_lat = cyc;
                cur = {byte_start_o, byte_stop_o, byte_read_o, byte_write_o, byte_ack_o, byte_din_o};
                if (obs_n < 10)
                    obs_seq[12*obs_n +: 12] = {byte_start_o, byte_stop_o, byte_read_o, byte_write_o,
                        byte_write_o ? byte_din_o : {7'b0, byte_read_o & byte_ack_o}};
                obs_n++;
            end
            if (active) begin
                hi++; obs_hi_last = hi;
                if ({byte_start_o, byte_stop_o, byte_read_o, byte_write_o, byte_ack_o, byte_din_o} !== cur)
                    obs_viol++;
                if (k == abort_k) return;
                if (k == al_k && hi == 1) begin
                    byte_al_i = 1'b1; byte_done_i = 1'b1;
                end else if (k != stall_k && hi > wait_n) begin
                    byte_done_i = 1'b1;
                    byte_ack_i  = (k == nack_k);
                    byte_dout_i = rd[8*rn +: 8];
                    if (byte_read_o) rn++;
                end
            end
        end
        if (!got_rsp) begin obs_to = 1; return; end
        obs_rdata = rsp_rdata_o; obs_err = rsp_err_o;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk_i);
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== obs_rdata || rsp_err_o !== obs_err ||
                req_ready_o !== 1'b0 || (byte_read_o | byte_write_o | byte_stop_o) !== 1'b0)
                obs_viol++;
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) obs_viol++;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (outs_now() !== {1'b1, 48'b0})
            $display("FAIL reset_outputs: got %h, want %h", outs_now(), {1'b1, 48'b0});
        else n_pass++;
        rst_i = 1'b0;
    endtask

    task automatic test_write();
        run_txn(1'b0, 7'h50, 8'h10, 2'd0, 32'h0000_00A5, 32'h0, -1, -1, -1, -1, 0);
        n_checks++;
        if (obs_n !== 4 || obs_seq[47:0] !== 48'h400_1A5_110_9A0)
            $display("FAIL write_cmds: got n=%0d seq=%h, want n=4 seq=4001a51109a0", obs_n, obs_seq[47:0]);
        else n_pass++;
        n_checks++;
        if (obs_err !== 2'b00 || obs_rdata !== 32'h0)
            $display("FAIL write_rsp: got err=%b rdata=%h, want err=00 rdata=0", obs_err, obs_rdata);
        else n_pass++;
        n_checks++;
        if (obs_viol !== 0 || obs_lat !== 0 || obs_gap !== 0 || obs_to)
            $display("FAIL write_proto: got viol=%0d lat=%0d gap=%0d to=%0d, want 0 0 0 0",
                     obs_viol, obs_lat, obs_gap, obs_to);
        else n_pass++;
    endtask

    task automatic test_read_hold();
        run_txn(1'b1, 7'h50, 8'h10, 2'd1, 32'h0, 32'h0000_3412, -1, -1, -1, -1, 5);
        n_checks++;
        if (obs_n !== 6 || obs_seq[71:0] !== 72'h400_201_200_9A1_110_9A0)
            $display("FAIL read_cmds: got n=%0d seq=%h, want n=6 seq=4002012009a11109a0", obs_n, obs_seq[71:0]);
        else n_pass++;
        n_checks++;
        if (obs_err !== 2'b00 || obs_rdata !== 32'h0000_3412)
            $display("FAIL read_rsp: got err=%b rdata=%h, want err=00 rdata=00003412", obs_err, obs_rdata);
        else n_pass++;
        n_checks++;
        if (obs_viol !== 0 || obs_gap !== 0 || obs_to)
            $display("FAIL read_hold_proto: got viol=%0d gap=%0d to=%0d, want 0 0 0", obs_viol, obs_gap, obs_to);
        else n_pass++;
    endtask

    task automatic test_nack_dev();
        run_txn(1'b0, 7'h50, 8'h10, 2'd2, 32'h00C0_FFEE, 32'h0, 0, -1, -1, -1, 1);
        n_checks++;
        if (obs_n !== 2 || obs_seq[23:0] !== 24'h400_9A0)
            $display("FAIL nack_cmds: got n=%0d seq=%h, want n=2 seq=4009a0", obs_n, obs_seq[23:0]);
        else n_pass++;
        n_checks++;
        if (obs_err !== 2'b01 || obs_viol !== 0 || obs_to)
            $display("FAIL nack_rsp: got err=%b viol=%0d to=%0d, want err=01 viol=0 to=0", obs_err, obs_viol, obs_to);
        else n_pass++;
    endtask

    task automatic test_arb_lost();
        run_txn(1'b0, 7'h50, 8'h10, 2'd0, 32'h0000_0077, 32'h0, -1, 1, -1, -1, 0);
        n_checks++;
        if (obs_n !== 2 || obs_seq[23:0] !== 24'h110_9A0)
            $display("FAIL al_cmds: got n=%0d seq=%h, want n=2 seq=1109a0", obs_n, obs_seq[23:0]);
        else n_pass++;
        n_checks++;
        if (obs_err !== 2'b10 || obs_gap !== 0 || obs_viol !== 0 || obs_to)
            $display("FAIL al_rsp: got err=%b gap=%0d viol=%0d, want err=10 gap=0 viol=0", obs_err, obs_gap, obs_viol);
        else n_pass++;
    endtask

    task automatic test_timeout();
        run_txn(1'b1, 7'h2C, 8'h44, 2'd3, 32'h0, 32'h0, -1, -1, 0, -1, 0);
        n_checks++;
        if (obs_n !== 1 || obs_seq[11:0] !== 12'h958 || obs_err !== 2'b11)
            $display("FAIL tmo_rsp: got n=%0d seq=%h err=%b, want n=1 seq=958 err=11", obs_n, obs_seq[11:0], obs_err);
        else n_pass++;
        n_checks++;
        if (obs_hi_last !== TMO || obs_gap !== 0 || obs_viol !== 0)
            $display("FAIL tmo_len: got hi=%0d gap=%0d viol=%0d, want hi=%0d gap=0 viol=0",
                     obs_hi_last, obs_gap, obs_viol, TMO);
        else n_pass++;
        run_txn(1'b0, 7'h2C, 8'h45, 2'd0, 32'h0000_0033, 32'h0, -1, -1, -1, -1, 0);
        n_checks++;
        if (obs_n !== 4 || obs_seq[47:0] !== 48'h400_133_145_958 || obs_err !== 2'b00 || obs_to)
            $display("FAIL tmo_recover: got n=%0d seq=%h err=%b, want n=4 seq=400133145958 err=00",
                     obs_n, obs_seq[47:0], obs_err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 2; t++) begin
            run_txn(1'b0, 7'h11, 8'(8'hF0 + t), 2'd3, 32'h4433_2211, 32'h0, -1, -1, -1, -1, 0);
            model(1'b0, 7'h11, 8'(8'hF0 + t), 2'd3, 32'h4433_2211, 32'h0, -1, -1, -1);
            n_checks++;
            if (obs_n !== exp_n || obs_seq !== exp_seq || obs_err !== exp_err || obs_viol !== 0 || obs_to)
                $display("FAIL b2b_%0d: got n=%0d seq=%h err=%b viol=%0d, want n=%0d seq=%h err=%b viol=0",
                         t, obs_n, obs_seq, obs_err, obs_viol, exp_n, exp_seq, exp_err);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic rw; logic [6:0] dev; logic [7:0] rg; logic [1:0] len; logic [31:0] wd, rd;
        int nk, ak, sk;
        for (int t = 0; t < 40; t++) begin
            rw = 1'($urandom); dev = 7'($urandom); rg = 8'($urandom); len = 2'($urandom);
            wd = $urandom; rd = $urandom;
            nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            ak = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8)) : -1;
            sk = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 8)) : -1;
            model(rw, dev, rg, len, wd, rd, nk, ak, sk);
            run_txn(rw, dev, rg, len, wd, rd, nk, ak, sk, -1, int'($urandom_range(0, 3)));
            n_checks++;
            if (obs_n !== exp_n || obs_seq !== exp_seq)
                $display("FAIL rand_cmds[%0d]: got n=%0d seq=%h, want n=%0d seq=%h", t, obs_n, obs_seq, exp_n, exp_seq);
            else n_pass++;
            n_checks++;
            if (obs_rdata !== exp_rdata || obs_err !== exp_err || obs_viol !== 0 || obs_to || obs_gap !== 0)
                $display("FAIL rand_rsp[%0d]: got rdata=%h err=%b viol=%0d to=%0d gap=%0d, want rdata=%h err=%b 0 0 0",
                         t, obs_rdata, obs_err, obs_viol, obs_to, obs_gap, exp_rdata, exp_err);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_read();
        // abort while the second READ command is outstanding (first byte stored)
        run_txn(1'b1, 7'h3A, 8'h01, 2'd3, 32'h0, 32'h0000_005A, -1, -1, -1, 4, 0);
        n_checks++;
        if (obs_n !== 5 || byte_read_o !== 1'b1 || rsp_rdata_o[7:0] !== 8'h5A)
            $display("FAIL rst_setup: got n=%0d read=%b rdata=%h, want n=5 read=1 rdata[7:0]=5a",
                     obs_n, byte_read_o, rsp_rdata_o);
        else n_pass++;
        #2 rst_i = 1'b1;
        #1;
        n_checks++;
        if (outs_now() !== {1'b1, 48'b0})
            $display("FAIL rst_async: got %h, want %h", outs_now(), {1'b1, 48'b0});
        else n_pass++;
        @(negedge clk_i);
        rst_i = 1'b0;
        run_txn(1'b0, 7'h3A, 8'h02, 2'd1, 32'h0000_BEEF, 32'h0, -1, -1, -1, -1, 0);
        n_checks++;
        if (obs_n !== 5 || obs_seq[59:0] !== 60'h400_1BE_1EF_102_974 || obs_err !== 2'b00 || obs_to)
            $display("FAIL rst_recover: got n=%0d seq=%h err=%b, want n=5 seq=4001be1ef102974 err=00",
                     obs_n, obs_seq[59:0], obs_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_hold();
        test_nack_dev();
        test_arb_lost();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/i2c_xfer_seq.md
# i2c_xfer_seq

Transaction sequencer for the I2C byte-level controller inside the AXI-Lite I2C master. It accepts one register-style transaction (device address, register address, 1–4 data bytes, read or write), turns it into the byte-command sequence START/WRITE/RESTART/READ/STOP, and returns read data and a status code. It removes per-byte CPU polling and sits between a request source (CSR block or DMA) and the byte controller's command port.

## Interface
Parameters:
- REG_ADDR_BYTES, 1: register-address bytes sent, 1 or 2, MSB first
- TIMEOUT_CYCLES, 100000: max cycles one byte command may wait for completion

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_rw_i  in  1  1 = read, 0 = write
- req_dev_i  in  7  7-bit device address
- req_reg_i  in  8*REG_ADDR_BYTES  register address
- req_len_i  in  2  data bytes minus 1 (0..3 → 1..4 bytes)
- req_wdata_i  in  32  write data, first byte on bus = [7:0]
- rsp_valid_o  out  1  response valid, held until rsp_ready_i
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  32  read data, first byte received in [7:0], unused bytes 0
- rsp_err_o  out  2  00 ok, 01 slave NACK, 10 arbitration lost, 11 timeout
- byte_start_o / byte_stop_o / byte_read_o / byte_write_o  out  1 each  byte-controller commands
- byte_ack_o  out  1  master ACK bit for reads (0 = ACK, 1 = NACK)
- byte_din_o  out  8  byte to transmit
- byte_done_i  in  1  one-cycle command-complete pulse
- byte_ack_i  in  1  slave ACK after write (0 = ACK)
- byte_dout_i  in  8  received byte, valid with byte_done_i
- byte_al_i  in  1  arbitration lost pulse

## Operation
- States: IDLE, DEV_W, REG, WDATA, RESTART, RDATA, STOP, RSP.
- IDLE: req_ready_o=1; on handshake, latch all req fields, clear rdata, clear byte index, go DEV_W.
- DEV_W: start+write, din = {dev,1'b0}. Done → REG.
- REG: write register bytes MSB first, REG_ADDR_BYTES commands. After last: write → WDATA, read → RESTART.
- WDATA: write bytes 0..len from req_wdata_i. After last → STOP.
- RESTART: start+write, din = {dev,1'b1}. Done → RDATA.
- RDATA: read commands; byte_ack_o=0 except last byte =1 (NACK). byte_dout_i stored in byte[idx]. After last → STOP.
- STOP: stop only (no read/write). Done → RSP.
- RSP: rsp_valid_o=1, outputs stable; on rsp_ready_i → IDLE.
- NACK: any write-command done with byte_ack_i=1 → err=01, remaining bytes skipped, go STOP.
- Arbitration lost: byte_al_i in any command state → err=10, command dropped, go RSP directly (no STOP).
- Timeout: counter reloads at each command issue, counts while waiting; reaching TIMEOUT_CYCLES → err=11, commands dropped, go RSP (no STOP).
- Priority in same cycle: byte_al_i > timeout > byte_done_i.
- First error code sticks; err cleared at request accept.

## Timing
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, all byte_* outputs 0, state IDLE.
- All outputs registered. Command asserted the cycle after entering a command state; held level, with din/ack stable, until byte_done_i sampled high; dropped the next cycle; next command asserted the following cycle (≥1 idle cycle between commands).
- req_ready_o is 0 from the cycle after acceptance until return to IDLE; back-to-back requests are separated by ≥1 cycle after rsp handshake.
- rsp_valid_o rises the cycle after STOP done (or error); falls the cycle after rsp_valid_o&rsp_ready_i.
- Reset mid-transaction: all commands drop asynchronously, state IDLE, no response generated; the byte controller shares rst_i.

## Test plan
- Write dev 0x50, reg 0x10, len 0, wdata 0xA5 → start+write 0xA0, write 0x10, write 0xA5, stop; rsp err 00.
- Read dev 0x50, reg 0x10, len 1, model returns 0x12, 0x34 → start+write 0xA0, write 0x10, start+write 0xA1, read ack0 → 0x12, read ack1 → 0x34, stop; rsp_rdata 0x00003412, err 00.
- Write with byte_ack_i=1 on device byte → no reg byte, stop issued, err 01.
- byte_al_i pulse during reg byte → no stop command, rsp err 10 next cycle.
- byte_done_i withheld, TIMEOUT_CYCLES=16 → commands drop after 16 cycles, err 11; next request accepted normally.
- rsp_ready_i low 5 cycles → rsp_valid_o/data/err stable, req_ready_o 0 until handshake; rst_i pulse mid-read → all outputs at reset values immediately.
